// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Ports: clk/reset; start+op+a+b launch an operation; mthi/mtlo+wdata write HI/LO directly;
//        busy/done report progress; hi/lo are the registered results.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               div_q;     // operation is a divide
    logic               neg_q_q;   // negate product / quotient at the end
    logic               neg_r_q;   // negate remainder at the end
    logic               dbz_q;     // divisor was zero
    logic [WIDTH-1:0]   a_q;       // raw dividend, returned as HI on divide by zero
    logic [WIDTH-1:0]   opb_q;     // multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0]   acc_q;     // product high half or partial remainder
    logic [WIDTH-1:0]   work_q;    // multiplier bits / dividend bits -> quotient bits
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;

    // operand capture helpers
    logic               sgn_op;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;

    // one-iteration datapath
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   acc_d;
    logic [WIDTH-1:0]   work_d;

    // final sign-corrected results
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   hi_d;
    logic [WIDTH-1:0]   lo_d;

    always_comb begin
        sgn_op = ~op[0];
        a_abs  = (sgn_op && a[WIDTH-1]) ? -a : a;
        b_abs  = (sgn_op && b[WIDTH-1]) ? -b : b;
    end

    always_comb begin
        // multiply: add multiplicand when the low multiplier bit is set, then shift right
        mul_sum   = {1'b0, acc_q} + (work_q[0] ? {1'b0, opb_q} : '0);
        // restoring divide: shift next dividend bit into the remainder, trial subtract
        div_shift = {acc_q, work_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        if (div_q) begin
            // a non-negative difference always fits WIDTH bits since remainder < divisor
            acc_d  = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            work_d = {work_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
            acc_d  = mul_sum[WIDTH:1];
            work_d = {mul_sum[0], work_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod = {acc_q, work_q};
        if (neg_q_q) prod = -prod;
        if (!div_q) begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
        end else if (dbz_q) begin
            hi_d = a_q;
            lo_d = '1;
        end else begin
            // most-negative / -1 falls out naturally: quotient magnitude 2^(W-1), no negation
            hi_d = neg_r_q ? -acc_q : acc_q;
            lo_d = neg_q_q ? -work_q : work_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            dbz_q   <= 1'b0;
            a_q     <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            work_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        div_q   <= op[1];
                        neg_q_q <= sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r_q <= sgn_op & a[WIDTH-1];
                        dbz_q   <= (b == '0);
                        a_q     <= a;
                        opb_q   <= op[1] ? b_abs : a_abs;
                        work_q  <= op[1] ? a_abs : b_abs;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end else begin
                        if (mthi) hi_q <= wdata;
                        if (mtlo) lo_q <= wdata;
                    end
                end
                RUN: begin
                    acc_q  <= acc_d;
                    work_q <= work_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= FIX;
                end
                FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  a, b;
    logic          mthi, mtlo;
    logic [W-1:0]  wdata;
    logic          busy, done;
    logic [W-1:0]  hi, lo;

    int total_cnt  = 0;
    int passed_cnt = 0;

    mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // Reference: {hi, lo} from plain arithmetic on the architectural operands.
    function automatic logic [63:0] model(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb);
        logic [63:0] r;
        int          sa, sb, q, rm;
        case (mop)
            2'd0: r = longint'($signed(ma)) * longint'($signed(mb));
            2'd1: r = {32'd0, ma} * {32'd0, mb};
            2'd2: begin
                if (mb == 32'd0) r = {ma, 32'hFFFF_FFFF};
                else if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
                else begin
                    sa = ma; sb = mb;
                    q  = sa / sb;
                    rm = sa % sb;
                    r  = {rm, q};
                end
            end
            default: begin
                if (mb == 32'd0) r = {ma, 32'hFFFF_FFFF};
                else r = {ma % mb, ma / mb};
            end
        endcase
        return r;
    endfunction

    // Launch one operation from IDLE and check latency, busy window, result, and done width.
    task automatic do_op(input logic [1:0] dop, input logic [31:0] da, input logic [31:0] db,
                         input logic [63:0] exp, input string tag);
        int cyc, bcnt;
        start = 1'b1; op = dop; a = da; b = db;
        @(posedge clk); #1;
        start = 1'b0;
        // operands are free to change after acceptance
        a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
        cyc = 0; bcnt = 0;
        while (!done && cyc < 100) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            cyc++;
        end
        total_cnt++;
        if (done !== 1'b1) $display("FAIL %s done_timeout: done=%b after %0d cycles", tag, done, cyc);
        else passed_cnt++;
        total_cnt++;
        if (cyc !== W + 1) $display("FAIL %s latency: got %0d want %0d", tag, cyc, W + 1);
        else passed_cnt++;
        total_cnt++;
        if (bcnt !== W + 1) $display("FAIL %s busy_cycles: got %0d want %0d", tag, bcnt, W + 1);
        else passed_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL %s busy_at_done: got %b want 0", tag, busy);
        else passed_cnt++;
        total_cnt++;
        if (hi !== exp[63:32]) $display("FAIL %s hi: got %h want %h (op=%0d a=%h b=%h)", tag, hi, exp[63:32], dop, da, db);
        else passed_cnt++;
        total_cnt++;
        if (lo !== exp[31:0]) $display("FAIL %s lo: got %h want %h (op=%0d a=%h b=%h)", tag, lo, exp[31:0], dop, da, db);
        else passed_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL %s done_pulse_width: got %b want 0", tag, done);
        else passed_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if ({busy, done} !== 2'b00) $display("FAIL reset_flags: busy/done got %b want 00", {busy, done});
        else passed_cnt++;
        total_cnt++;
        if ({hi, lo} !== 64'd0) $display("FAIL reset_hilo: got %h want 0", {hi, lo});
        else passed_cnt++;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        do_op(2'd0, 32'hFFFF_FFFD, 32'd7,        64'hFFFF_FFFF_FFFF_FFEB, "mult_neg3x7");
        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "multu_max");
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2,        64'hFFFF_FFFF_FFFF_FFFD, "div_neg7by2");
        do_op(2'd2, 32'd7,        32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, "div_7byneg2");
        do_op(2'd3, 32'd100,      32'd0,         64'h0000_0064_FFFF_FFFF, "divu_by0");
        do_op(2'd2, 32'hFFFF_FF00, 32'd0,        64'hFFFF_FF00_FFFF_FFFF, "div_by0");
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, "div_minneg1");
        do_op(2'd3, 32'hFFFF_FFFF, 32'd16,       64'h0000_000F_0FFF_FFFF, "divu_big");
    endtask

    task automatic test_random();
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 9));
                3: ra = 32'($urandom_range(0, 50));
                default: ;
            endcase
            do_op(rop, ra, rb, model(rop, ra, rb), "random");
        end
    endtask

    task automatic test_mtx();
        logic [31:0] w;
        int cyc;
        mthi = 1'b1; wdata = 32'hCAFE_0000;
        @(posedge clk); #1;
        mthi = 1'b0;
        mtlo = 1'b1; wdata = 32'h0000_1234;
        @(posedge clk); #1;
        mtlo = 1'b0;
        total_cnt++;
        if (lo !== 32'h0000_1234) $display("FAIL mtlo_lo: got %h want 00001234", lo);
        else passed_cnt++;
        total_cnt++;
        if (hi !== 32'hCAFE_0000) $display("FAIL mtlo_hi_kept: got %h want cafe0000", hi);
        else passed_cnt++;
        w = $urandom;
        mthi = 1'b1; mtlo = 1'b1; wdata = w;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        total_cnt++;
        if ({hi, lo} !== {w, w}) $display("FAIL mthilo_both: got %h want %h", {hi, lo}, {w, w});
        else passed_cnt++;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({hi, lo} !== {w, w}) $display("FAIL idle_hold: got %h want %h", {hi, lo}, {w, w});
        else passed_cnt++;
        // start with mthi in the same cycle: the write is dropped
        start = 1'b1; op = 2'd1; a = 32'd5; b = 32'd6; mthi = 1'b1; wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0;
        total_cnt++;
        if (hi !== w) $display("FAIL start_mthi_drop: got %h want %h", hi, w);
        else passed_cnt++;
        cyc = 0;
        while (!done && cyc < 100) begin @(posedge clk); #1; cyc++; end
        total_cnt++;
        if ({done, hi, lo} !== {1'b1, 32'd0, 32'd30}) $display("FAIL start_mthi_result: got %b %h %h want 1 0 1e", done, hi, lo);
        else passed_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_busy_ignore();
        logic [31:0] fa, fb, ha, la;
        logic [63:0] exp;
        int dcnt, dcyc;
        fa = $urandom; fb = $urandom;
        exp = model(2'd0, fa, fb);
        start = 1'b1; op = 2'd0; a = fa; b = fb;
        @(posedge clk); #1;
        start = 1'b0;
        dcnt = 0; dcyc = 0; ha = '0; la = '0;
        for (int i = 1; i <= 50; i++) begin
            if (i == 10) begin
                start = 1'b1; op = 2'd3; a = $urandom; b = $urandom;
                mthi = 1'b1; wdata = $urandom;
            end
            @(posedge clk); #1;
            if (i == 10) begin start = 1'b0; mthi = 1'b0; end
            if (done) begin dcnt++; dcyc = i; ha = hi; la = lo; end
        end
        total_cnt++;
        if (dcnt !== 1) $display("FAIL busy_ignore_done_count: got %0d want 1", dcnt);
        else passed_cnt++;
        total_cnt++;
        if (dcyc !== W + 1) $display("FAIL busy_ignore_done_cycle: got %0d want %0d", dcyc, W + 1);
        else passed_cnt++;
        total_cnt++;
        if ({ha, la} !== exp) $display("FAIL busy_ignore_result: got %h want %h", {ha, la}, exp);
        else passed_cnt++;
        total_cnt++;
        if ({hi, lo} !== exp) $display("FAIL busy_ignore_final: got %h want %h", {hi, lo}, exp);
        else passed_cnt++;
    endtask

    task automatic test_reset_mid();
        int dcnt;
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_5A5A;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        start = 1'b1; op = 2'd3; a = $urandom; b = 32'($urandom_range(1, 1000));
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        total_cnt++;
        if ({busy, done} !== 2'b00) $display("FAIL midreset_flags: busy/done got %b want 00", {busy, done});
        else passed_cnt++;
        total_cnt++;
        if ({hi, lo} !== 64'd0) $display("FAIL midreset_hilo: got %h want 0", {hi, lo});
        else passed_cnt++;
        @(posedge clk); #1;
        reset = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) dcnt++;
        end
        total_cnt++;
        if (dcnt !== 0) $display("FAIL midreset_no_done: active cycles got %0d want 0", dcnt);
        else passed_cnt++;
        do_op(2'd1, 32'd3, 32'd4, 64'd12, "after_reset_multu");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mtx();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand width and width of each of HI and LO; legal values 8..64, even.
REQ-002 Parameter CNT_W, default 6, iteration-counter width; shall satisfy 2^CNT_W > WIDTH.
REQ-003 clk  input  1  rising-edge clock, the single clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to begin an operation; sampled on rising edges.
REQ-006 op  input  2  operation: 0 MULT (signed), 1 MULTU, 2 DIV (signed), 3 DIVU.
REQ-007 a  input  WIDTH  multiplicand or dividend; captured with start.
REQ-008 b  input  WIDTH  multiplier or divisor; captured with start.
REQ-009 mthi, mtlo  input  1 each  direct write of wdata into HI or LO.
REQ-010 wdata  input  WIDTH  data for mthi/mtlo.
REQ-011 busy  output  1  high while an operation is in progress.
REQ-012 done  output  1  one-cycle pulse; HI/LO hold the new result in this cycle.
REQ-013 hi, lo  output  WIDTH each  registered HI and LO.

Function
REQ-014 The FSM shall have three states: IDLE, RUN, FIX; busy = (state != IDLE).
REQ-015 start in IDLE at edge E0 shall capture op, capture the operand magnitudes (absolute values for signed ops), record the result signs, clear the counter, and go to RUN.
REQ-016 RUN shall perform one iteration per edge: shift-add for multiply, restoring shift-subtract for divide; increment the counter.
REQ-017 At edge E_WIDTH, after WIDTH iterations, the FSM shall go to FIX.
REQ-018 At edge E_WIDTH+1, FIX shall apply sign correction, write hi/lo, and go to IDLE; done shall be 1 in the following cycle only.
REQ-019 Latency: busy shall be high for exactly WIDTH+1 cycles; done shall follow start acceptance by WIDTH+1 cycles.
REQ-020 Multiply: {hi,lo} = full 2*WIDTH-bit product, two's-complement for MULT.
REQ-021 Divide: lo = quotient, truncated toward zero; hi = remainder, taking the sign of the dividend for DIV.
REQ-022 Divide by zero shall take the same latency, with hi = a and lo = all ones, for DIV and DIVU.
REQ-023 DIV of most-negative by -1 shall give lo = most-negative and hi = 0.
REQ-024 start while busy shall be ignored; the current operation is unaffected.
REQ-025 mthi/mtlo in IDLE without start shall update hi/lo at that edge; both asserted together shall write both.
REQ-026 mthi/mtlo shall be ignored while busy, and also when start is accepted in the same cycle.
REQ-027 hi/lo shall hold their value except when written by REQ-018 or REQ-025.
REQ-028 Operands a and b may change after E0 without affecting the result.

Reset
REQ-029 Asserting reset at any time shall immediately force state = IDLE, hi = 0, lo = 0, counter = 0, busy = 0, done = 0.
REQ-030 Reset asserted mid-operation shall abort the operation with no hi/lo update and no done pulse.
REQ-031 After reset deasserts, the first start shall be accepted normally.

Verification (WIDTH=32)
REQ-032 MULT with a=0xFFFFFFFD (-3), b=7 -> done 33 cycles after acceptance; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-033 MULTU with a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 DIV with a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU with a=100, b=0 -> hi=100, lo=0xFFFFFFFF; DIV with a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
REQ-035 Second start and mthi=1 pulsed at cycle 10 of a busy operation -> both ignored; only the first result is written, with a single done pulse.
REQ-036 reset pulsed at cycle 15 of a DIVU -> busy=0 and hi=lo=0 immediately; no done; a following MULTU 3*4 gives lo=12, hi=0.
REQ-037 mtlo with wdata=0x1234 in IDLE -> lo=0x1234 next cycle with hi unchanged; start and mthi in the same cycle -> mthi dropped.
